// File: rtl/majority_pkg.sv
// Shared helpers for N-input majority voters: bit majority, clog2 and
// elaboration-time parameter legality.
package majority_pkg;

   localparam int MAX_N_IN = 15;

   function automatic int clog2(input int value);
      int res;
      res = 0;
      while ((32'sd1 <<< res) < value) begin
         res = res + 1;
      end
      return res;
   endfunction

   // Channels above n are ignored so one function serves every voter width.
   function automatic logic maj_bit(input logic [MAX_N_IN-1:0] vec, input int n);
      int ones;
      ones = 0;
      for (int i = 0; i < MAX_N_IN; i++) begin
         if ((i < n) && vec[i]) begin
            ones = ones + 1;
         end else begin
            ones = ones + 0;
         end
      end
      return (ones > (n / 2));
   endfunction

   function automatic bit params_ok(input int n_in, input int width,
                                    input int thresh, input int cnt_w);
      return ((n_in % 2) == 1) && (n_in >= 3) && (n_in <= MAX_N_IN) &&
             (width >= 1) && (thresh >= 1) && (thresh <= 255) && (cnt_w >= 1);
   endfunction

endpackage

// File: rtl/majority_bit_n.sv
// Combinational N_IN-input single-bit majority gate.
module majority_bit_n
   import majority_pkg::*;
#(
   parameter int N_IN = 3
) (
   input  logic [N_IN-1:0] bits_i,
   output logic            maj_o
);

   logic [MAX_N_IN-1:0] padded_s;

   // Zero-extend the column to the package function's fixed width.
   always_comb begin
      padded_s = {MAX_N_IN{1'b0}};
      padded_s[N_IN-1:0] = bits_i;
      maj_o = maj_bit(padded_s, N_IN);
   end

endmodule

// File: rtl/majority_voter_n.sv
// N-input, WIDTH-bit bitwise majority voter with registered vote,
// per-channel disagreement streaks, sticky fault flags and a mismatch counter.
module majority_voter_n
   import majority_pkg::*;
#(
   parameter int N_IN         = 3,
   parameter int WIDTH        = 8,
   parameter int FAULT_THRESH = 4,
   parameter int CNT_W        = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   input  logic [N_IN*WIDTH-1:0] in_data,
   input  logic                  clear_faults,
   output logic [WIDTH-1:0]      vote_out,
   output logic                  out_valid,
   output logic                  unanimous,
   output logic [N_IN-1:0]       disagree,
   output logic [N_IN-1:0]       fault,
   output logic [CNT_W-1:0]      mismatch_cnt
);

   localparam int STREAK_W = clog2(FAULT_THRESH + 1);
   localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(FAULT_THRESH);
   localparam logic [STREAK_W-1:0] STREAK_ONE = STREAK_W'(32'd1);
   localparam logic [CNT_W-1:0]    CNT_MAX    = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0]    CNT_ONE    = CNT_W'(32'd1);

   if (!params_ok(N_IN, WIDTH, FAULT_THRESH, CNT_W)) begin : g_param_check
      $error("majority_voter_n: illegal parameters N_IN=%0d WIDTH=%0d FAULT_THRESH=%0d CNT_W=%0d",
             N_IN, WIDTH, FAULT_THRESH, CNT_W);
   end

   logic [WIDTH-1:0]    vote_s;
   logic [N_IN-1:0]     disagree_s;

   logic [WIDTH-1:0]    vote_q,      vote_d;
   logic                out_valid_q, out_valid_d;
   logic                unanimous_q, unanimous_d;
   logic [N_IN-1:0]     disagree_q,  disagree_d;
   logic [N_IN-1:0]     fault_q,     fault_d;
   logic [CNT_W-1:0]    cnt_q,       cnt_d;
   logic [STREAK_W-1:0] streak_q [N_IN];
   logic [STREAK_W-1:0] streak_d [N_IN];

   for (genvar b = 0; b < WIDTH; b++) begin : g_bit
      logic [N_IN-1:0] col_s;

      // Gather bit b of every channel into one voting column.
      always_comb begin
         col_s = {N_IN{1'b0}};
         for (int i = 0; i < N_IN; i++) begin
            col_s[i] = in_data[i*WIDTH + b];
         end
      end

      majority_bit_n #(.N_IN(N_IN)) u_maj (
         .bits_i (col_s),
         .maj_o  (vote_s[b])
      );
   end

   // A channel disagrees if any of its bits differs from the vote.
   always_comb begin
      disagree_s = {N_IN{1'b0}};
      for (int i = 0; i < N_IN; i++) begin
         disagree_s[i] = |(in_data[i*WIDTH +: WIDTH] ^ vote_s);
      end
   end

   // Next-state for the output stage, streaks, faults and mismatch counter.
   always_comb begin
      vote_d      = vote_q;
      out_valid_d = 1'b0;
      unanimous_d = 1'b0;
      disagree_d  = {N_IN{1'b0}};
      fault_d     = fault_q;
      cnt_d       = cnt_q;
      for (int i = 0; i < N_IN; i++) begin
         streak_d[i] = streak_q[i];
      end

      if (in_valid) begin
         vote_d      = vote_s;
         out_valid_d = 1'b1;
         disagree_d  = disagree_s;
         unanimous_d = (disagree_s == {N_IN{1'b0}});
         if ((disagree_s != {N_IN{1'b0}}) && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_ONE;
         end else begin
            cnt_d = cnt_q;
         end
      end else begin
         vote_d = vote_q;
      end

      // Clear beats a coincident sample: its disagreement is not counted.
      if (clear_faults) begin
         fault_d = {N_IN{1'b0}};
         for (int i = 0; i < N_IN; i++) begin
            streak_d[i] = {STREAK_W{1'b0}};
         end
      end else if (in_valid) begin
         for (int i = 0; i < N_IN; i++) begin
            if (disagree_s[i]) begin
               if (streak_q[i] != STREAK_MAX) begin
                  streak_d[i] = streak_q[i] + STREAK_ONE;
               end else begin
                  streak_d[i] = streak_q[i];
               end
               if (streak_d[i] == STREAK_MAX) begin
                  fault_d[i] = 1'b1;
               end else begin
                  fault_d[i] = fault_q[i];
               end
            end else begin
               streak_d[i] = {STREAK_W{1'b0}};
            end
         end
      end else begin
         fault_d = fault_q;
      end
   end

   // State registers with synchronous reset overriding everything.
   always_ff @(posedge clk) begin
      if (rst) begin
         vote_q      <= {WIDTH{1'b0}};
         out_valid_q <= 1'b0;
         unanimous_q <= 1'b0;
         disagree_q  <= {N_IN{1'b0}};
         fault_q     <= {N_IN{1'b0}};
         cnt_q       <= {CNT_W{1'b0}};
         for (int i = 0; i < N_IN; i++) begin
            streak_q[i] <= {STREAK_W{1'b0}};
         end
      end else begin
         vote_q      <= vote_d;
         out_valid_q <= out_valid_d;
         unanimous_q <= unanimous_d;
         disagree_q  <= disagree_d;
         fault_q     <= fault_d;
         cnt_q       <= cnt_d;
         for (int i = 0; i < N_IN; i++) begin
            streak_q[i] <= streak_d[i];
         end
      end
   end

   assign vote_out     = vote_q;
   assign out_valid    = out_valid_q;
   assign unanimous    = unanimous_q;
   assign disagree     = disagree_q;
   assign fault        = fault_q;
   assign mismatch_cnt = cnt_q;

endmodule

// File: doc/majority_voter_n.md
Name: majority_voter_n

Overview:
- Parametrised successor to the team's 3-input majority gate: N-input, WIDTH-bit bitwise majority voter with a registered output and channel-health tracking.
- Sits behind redundant (TMR/NMR) datapaths; delivers the voted word and flags channels that persistently disagree with the vote.
- Fault flags are for reporting only. Faulted channels still vote.

Parameters:
- N_IN, 3, number of redundant input channels; must be odd, 3..15 (elaboration error otherwise).
- WIDTH, 8, bits per channel.
- FAULT_THRESH, 4, consecutive disagreeing valid samples that set a channel's fault flag; range 1..255.
- CNT_W, 8, width of the saturating non-unanimous sample counter.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  in_data is valid this cycle.
- in_data  in  N_IN*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- clear_faults  in  1  single-cycle pulse; clears fault flags and streak counters.
- vote_out  out  WIDTH  registered bitwise majority.
- out_valid  out  1  vote_out, disagree and unanimous are valid.
- unanimous  out  1  all channels were equal for this sample.
- disagree  out  N_IN  bit i = channel i differed from the vote in at least one bit.
- fault  out  N_IN  sticky per-channel fault flag.
- mismatch_cnt  out  CNT_W  saturating count of non-unanimous valid samples.

Behaviour:
- Reset: synchronous. On any edge with rst=1, every output and internal register goes to 0: vote_out, out_valid, unanimous, disagree, fault, mismatch_cnt and all streak counters. rst overrides all other inputs, including a sample in flight. The first sample after release may arrive on the cycle rst falls.
- Vote: for each bit b, vote[b]=1 iff popcount over channels of in_data[i][b] > N_IN/2 (integer division). N_IN is odd, so ties are impossible.
- Latency: fixed 1 cycle. A sample with in_valid=1 at edge t produces vote_out/out_valid/disagree/unanimous after edge t. There is no backpressure; one sample per cycle is accepted.
- in_valid=0 cycle:
  - out_valid=0, disagree=0, unanimous=0.
  - vote_out holds its last value.
  - Streaks and mismatch_cnt hold. An invalid gap does not break a streak.
- disagree[i] = OR-reduce(in_data[i] XOR vote). unanimous = (disagree == 0).
- Streak counter per channel: width clog2(FAULT_THRESH+1), saturating at FAULT_THRESH.
  - Updated only on valid samples: increments if disagree[i], else resets to 0.
- Fault set: fault[i] sets on the same edge at which streak[i] reaches FAULT_THRESH, so it is visible together with out_valid for the FAULT_THRESH-th disagreeing sample. It stays set while the channel keeps disagreeing or later agrees; only clear_faults or rst clears it.
- clear_faults:
  - Zeroes fault[] and all streaks on that edge.
  - If it coincides with a valid sample, clear wins: that sample's disagreement is not counted, but its vote and disagree outputs are produced normally.
  - mismatch_cnt is not affected by clear_faults; only rst clears it.
- mismatch_cnt: +1 per valid non-unanimous sample; saturates at 2^CNT_W-1 (no wrap).
- in_data is ignored when in_valid=0 (X-tolerant).

Decomposition:
- Package majority_pkg holds:
  - function maj_bit(vector, n): popcount > n/2.
  - function clog2.
  - Parameter-legality checks shared by future voters.
- Sub-module majority_bit_n: combinational N_IN-input single-bit majority, generated WIDTH times inside majority_voter_n.
- Registers, streak counters, fault logic and mismatch_cnt live in the top module.

Test Plan:
- Config for all scenarios: N_IN=3, WIDTH=8, FAULT_THRESH=4, except scenario 6 which uses CNT_W=4.
- 1. Reset: rst=1 for 2 cycles with in_valid=1 and random data -> all outputs 0 throughout and on the first cycle after release.
- 2. Unanimous: ch0=ch1=ch2=0xA5, in_valid pulse -> one cycle later vote_out=0xA5, out_valid=1, unanimous=1, disagree=000, mismatch_cnt=0; next cycle out_valid=0 and vote_out still 0xA5.
- 3. Split vote: ch0=0xFF, ch1=0x0F, ch2=0xF0 -> vote_out=0xFF, disagree=110 (ch2,ch1), unanimous=0, mismatch_cnt=1.
- 4. Fault with gaps: ch0=ch1=0x3C, ch2=0x00 for 4 valid samples with in_valid=0 gaps between them -> fault=100 asserts with the 4th out_valid, not earlier. Then 2 agreeing samples -> fault stays 100.
- 5. Clear race: repeat scenario 4 but pulse clear_faults on the edge of the 4th disagreeing sample -> fault stays 000 and vote_out=0x3C. A further 3 disagreeing samples keep fault=000; the 4th sets it.
- 6. Saturation and mid-stream reset (CNT_W=4): 20 consecutive non-unanimous samples -> mismatch_cnt holds 15. Then rst=1 during the stream -> next cycle mismatch_cnt=0, fault=000, out_valid=0.
